fetch_pc_unit: RTL and testbench

// Owns the architectural PC and fetches aligned FETCH_WIDTH-instruction bundles from instruction memory.

---
 rtl/fetch_pc_unit_if.sv | 29 ++
 rtl/fetch_pc_unit.sv | 150 +++++++++++++++
 tb/tb_fetch_pc_unit.sv | 282 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_pc_unit_if.sv
// Fetch-side bus bundle: execute redirect, instruction-memory request/response
// and the bundle handed to decode. The fetch unit takes the master view.
interface fetch_pc_unit_if #(
    parameter int PC_WIDTH    = 16,
    parameter int FETCH_WIDTH = 2
);
    logic [PC_WIDTH-1:0]         branchpc;
    logic                        isbranchtaken;
    logic                        imem_req_valid;
    logic                        imem_req_ready;
    logic [PC_WIDTH-1:0]         imem_addr;
    logic                        imem_rsp_valid;
    logic [16*FETCH_WIDTH-1:0]   imem_rdata;
    logic                        fetch_valid;
    logic [PC_WIDTH-1:0]         fetch_pc;
    logic [FETCH_WIDTH-1:0]      fetch_slot_valid;
    logic [16*FETCH_WIDTH-1:0]   fetch_instr;
    logic                        decode_ready;

    modport master (
        input  branchpc, isbranchtaken, imem_req_ready, imem_rsp_valid, imem_rdata, decode_ready,
        output imem_req_valid, imem_addr, fetch_valid, fetch_pc, fetch_slot_valid, fetch_instr
    );

    modport slave (
        output branchpc, isbranchtaken, imem_req_ready, imem_rsp_valid, imem_rdata, decode_ready,
        input  imem_req_valid, imem_addr, fetch_valid, fetch_pc, fetch_slot_valid, fetch_instr
    );
endinterface

// File: rtl/fetch_pc_unit.sv
// Fetch PC unit: owns the architectural PC, issues one aligned bundle request
// at a time to instruction memory, holds the returned bundle for decode and
// retargets on execute-stage redirects, draining a response that was already
// in flight when the redirect landed.
module fetch_pc_unit #(
    parameter int                  PC_WIDTH    = 16,
    parameter int                  FETCH_WIDTH = 2,
    parameter logic [PC_WIDTH-1:0] RESET_PC    = {PC_WIDTH{1'b0}}
) (
    input  logic           clk,
    input  logic           rst,
    fetch_pc_unit_if.master bus
);

    localparam int                  OFF_W      = $clog2(FETCH_WIDTH);
    localparam int                  DATA_W     = 16 * FETCH_WIDTH;
    localparam logic [PC_WIDTH-1:0] FW_PC      = PC_WIDTH'(FETCH_WIDTH);
    localparam logic [PC_WIDTH-1:0] ALIGN_MASK = ~(PC_WIDTH'(FETCH_WIDTH - 1));

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_REQ   = 3'd1,
        ST_WAIT  = 3'd2,
        ST_HOLD  = 3'd3,
        ST_DRAIN = 3'd4
    } state_t;

    state_t               state_r;
    logic [PC_WIDTH-1:0]  pc_r;
    logic [PC_WIDTH-1:0]  req_pc_r;
    logic [OFF_W-1:0]     req_off_r;
    logic                 imem_req_valid_r;
    logic [PC_WIDTH-1:0]  imem_addr_r;
    logic                 fetch_valid_r;
    logic [PC_WIDTH-1:0]  fetch_pc_r;
    logic [FETCH_WIDTH-1:0] fetch_slot_valid_r;
    logic [DATA_W-1:0]    fetch_instr_r;
    logic                 outstanding_s;

    // Bundle-aligned word address of any PC.
    function automatic logic [PC_WIDTH-1:0] align_f(input logic [PC_WIDTH-1:0] addr);
        return addr & ALIGN_MASK;
    endfunction

    // Slots before the entry offset of an unaligned target are not valid.
    function automatic logic [FETCH_WIDTH-1:0] slot_mask_f(input logic [OFF_W-1:0] off);
        logic [FETCH_WIDTH-1:0] mask;
        mask = {FETCH_WIDTH{1'b0}};
        for (int i = 0; i < FETCH_WIDTH; i++) begin
            mask[i] = (i >= int'(off));
        end
        return mask;
    endfunction

    // A request is still owed a response after this edge if one is accepted now
    // or one is pending and its response does not arrive this cycle.
    always_comb begin
        outstanding_s = 1'b0;
        case (state_r)
            ST_REQ:   outstanding_s = bus.imem_req_ready;
            ST_WAIT:  outstanding_s = !bus.imem_rsp_valid;
            ST_DRAIN: outstanding_s = !bus.imem_rsp_valid;
            default:  outstanding_s = 1'b0;
        endcase
    end

    // Fetch control FSM with registered request and decode-side outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r            <= ST_IDLE;
            pc_r               <= RESET_PC;
            req_pc_r           <= {PC_WIDTH{1'b0}};
            req_off_r          <= RESET_PC[OFF_W-1:0];
            imem_req_valid_r   <= 1'b0;
            imem_addr_r        <= {PC_WIDTH{1'b0}};
            fetch_valid_r      <= 1'b0;
            fetch_pc_r         <= {PC_WIDTH{1'b0}};
            fetch_slot_valid_r <= {FETCH_WIDTH{1'b0}};
            fetch_instr_r      <= {DATA_W{1'b0}};
        end else if (bus.isbranchtaken) begin
            // Redirect wins over every other event: kill the held bundle and
            // either drain the in-flight response or request the target at once.
            pc_r               <= bus.branchpc;
            fetch_valid_r      <= 1'b0;
            fetch_slot_valid_r <= {FETCH_WIDTH{1'b0}};
            if (outstanding_s) begin
                state_r          <= ST_DRAIN;
                imem_req_valid_r <= 1'b0;
            end else begin
                state_r          <= ST_REQ;
                imem_req_valid_r <= 1'b1;
                imem_addr_r      <= align_f(bus.branchpc);
            end
        end else begin
            case (state_r)
                ST_IDLE: begin
                    state_r          <= ST_REQ;
                    imem_req_valid_r <= 1'b1;
                    imem_addr_r      <= align_f(pc_r);
                end
                ST_REQ: begin
                    if (bus.imem_req_ready) begin
                        req_pc_r         <= align_f(pc_r);
                        req_off_r        <= pc_r[OFF_W-1:0];
                        pc_r             <= align_f(pc_r) + FW_PC;
                        imem_req_valid_r <= 1'b0;
                        state_r          <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (bus.imem_rsp_valid) begin
                        fetch_instr_r      <= bus.imem_rdata;
                        fetch_pc_r         <= req_pc_r;
                        fetch_slot_valid_r <= slot_mask_f(req_off_r);
                        fetch_valid_r      <= 1'b1;
                        state_r            <= ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    if (bus.decode_ready) begin
                        fetch_valid_r    <= 1'b0;
                        state_r          <= ST_REQ;
                        imem_req_valid_r <= 1'b1;
                        imem_addr_r      <= align_f(pc_r);
                    end
                end
                ST_DRAIN: begin
                    if (bus.imem_rsp_valid) begin
                        state_r          <= ST_REQ;
                        imem_req_valid_r <= 1'b1;
                        imem_addr_r      <= align_f(pc_r);
                    end
                end
                default: begin
                    state_r          <= ST_IDLE;
                    imem_req_valid_r <= 1'b0;
                    fetch_valid_r    <= 1'b0;
                end
            endcase
        end
    end

    assign bus.imem_req_valid   = imem_req_valid_r;
    assign bus.imem_addr        = imem_addr_r;
    assign bus.fetch_valid      = fetch_valid_r;
    assign bus.fetch_pc         = fetch_pc_r;
    assign bus.fetch_slot_valid = fetch_slot_valid_r;
    assign bus.fetch_instr      = fetch_instr_r;

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Bench for fetch_pc_unit: a behavioural imem with programmable latency, a
// scoreboard of expected bundles consumed by decode, and directed redirect,
// stall, wrap and async-reset scenarios.
module tb_fetch_pc_unit;

    typedef struct {
        logic [15:0] pc;
        logic [1:0]  mask;
    } exp_t;

    logic clk;
    logic rst;
    int   errors_cnt;
    int   checks_cnt;
    int   consumed;
    int   rsp_lat;
    exp_t sb_q[$];

    fetch_pc_unit_if #(.PC_WIDTH(16), .FETCH_WIDTH(2)) bus_if ();

    fetch_pc_unit #(.PC_WIDTH(16), .FETCH_WIDTH(2), .RESET_PC(16'h0000)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    // Free-running clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [15:0] mem_word(input logic [15:0] a);
        return (a * 16'd7) ^ 16'hC35A;
    endfunction

    function automatic logic [31:0] mem_bundle(input logic [15:0] base);
        return {mem_word(base + 16'd1), mem_word(base)};
    endfunction

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks_cnt++;
        if (got !== exp) begin
            errors_cnt++;
            $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic push_exp(input logic [15:0] pc, input logic [1:0] mask);
        exp_t e;
        e.pc   = pc;
        e.mask = mask;
        sb_q.push_back(e);
    endtask

    // One clock: observe a consumed bundle at the falling edge, return just
    // after the next rising edge so callers can drive inputs for the next one.
    task automatic step();
        exp_t e;
        @(negedge clk);
        if (!rst && bus_if.fetch_valid && bus_if.decode_ready && !bus_if.isbranchtaken) begin
            consumed++;
            if (sb_q.size() == 0) begin
                check_val("sb_unexpected_bundle", 64'(sb_q.size()), 64'd1);
            end else begin
                e = sb_q.pop_front();
                check_val("sb_fetch_pc", 64'(bus_if.fetch_pc), 64'(e.pc));
                check_val("sb_slot_mask", 64'(bus_if.fetch_slot_valid), 64'(e.mask));
                check_val("sb_instr", 64'(bus_if.fetch_instr), 64'(mem_bundle(e.pc)));
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic run_until_consumed(input int n);
        int target;
        target = consumed + n;
        for (int i = 0; i < 60 && consumed < target; i++) begin
            step();
        end
        bus_if.imem_req_ready = 1'b0;
        if (consumed < target) begin
            check_val("consume_timeout", 64'(consumed), 64'(target));
        end
    endtask

    task automatic wait_fetch_valid();
        for (int i = 0; i < 20 && !bus_if.fetch_valid; i++) begin
            step();
        end
        check_val("fetch_valid_seen", 64'(bus_if.fetch_valid), 64'd1);
    endtask

    task automatic check_all_zero(input string tag);
        check_val({tag, "_req_valid"}, 64'(bus_if.imem_req_valid), 64'd0);
        check_val({tag, "_imem_addr"}, 64'(bus_if.imem_addr), 64'd0);
        check_val({tag, "_fetch_valid"}, 64'(bus_if.fetch_valid), 64'd0);
        check_val({tag, "_fetch_pc"}, 64'(bus_if.fetch_pc), 64'd0);
        check_val({tag, "_slot_valid"}, 64'(bus_if.fetch_slot_valid), 64'd0);
        check_val({tag, "_fetch_instr"}, 64'(bus_if.fetch_instr), 64'd0);
    endtask

    // Behavioural imem: accepts on valid&ready, answers once after rsp_lat cycles.
    initial begin : imem_model
        logic        fire;
        logic        pend;
        logic [15:0] faddr;
        logic [15:0] pend_addr;
        int          cnt;
        pend = 1'b0;
        pend_addr = 16'h0000;
        cnt = 0;
        bus_if.imem_rsp_valid = 1'b0;
        bus_if.imem_rdata = 32'h0000_0000;
        forever begin
            @(negedge clk);
            fire  = bus_if.imem_req_valid && bus_if.imem_req_ready && !rst;
            faddr = bus_if.imem_addr;
            @(posedge clk);
            #2;
            bus_if.imem_rsp_valid = 1'b0;
            if (rst) begin
                pend = 1'b0;
            end else begin
                if (fire) begin
                    pend = 1'b1;
                    pend_addr = faddr;
                    cnt = rsp_lat;
                end
                if (pend) begin
                    cnt--;
                    if (cnt <= 0) begin
                        bus_if.imem_rsp_valid = 1'b1;
                        bus_if.imem_rdata = mem_bundle(pend_addr);
                        pend = 1'b0;
                    end
                end
            end
        end
    end

    // Directed scenarios.
    initial begin
        errors_cnt = 0;
        checks_cnt = 0;
        consumed   = 0;
        rsp_lat    = 1;
        rst        = 1'b1;
        bus_if.branchpc       = 16'h0000;
        bus_if.isbranchtaken  = 1'b0;
        bus_if.imem_req_ready = 1'b0;
        bus_if.decode_ready   = 1'b0;

        // Reset state.
        step();
        step();
        check_all_zero("reset");

        // Sequential fetch from reset PC.
        rst = 1'b0;
        bus_if.decode_ready   = 1'b1;
        bus_if.imem_req_ready = 1'b1;
        step();
        check_val("first_req_valid", 64'(bus_if.imem_req_valid), 64'd1);
        check_val("first_req_addr", 64'(bus_if.imem_addr), 64'h0000);
        push_exp(16'h0000, 2'b11);
        push_exp(16'h0002, 2'b11);
        push_exp(16'h0004, 2'b11);
        run_until_consumed(3);
        check_val("seq_next_addr", 64'(bus_if.imem_addr), 64'h0006);

        // Decode stall in HOLD.
        bus_if.decode_ready   = 1'b0;
        bus_if.imem_req_ready = 1'b1;
        push_exp(16'h0006, 2'b11);
        wait_fetch_valid();
        bus_if.imem_req_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            check_val("hold_valid", 64'(bus_if.fetch_valid), 64'd1);
            check_val("hold_pc", 64'(bus_if.fetch_pc), 64'h0006);
            check_val("hold_instr", 64'(bus_if.fetch_instr), 64'(mem_bundle(16'h0006)));
            check_val("hold_no_req", 64'(bus_if.imem_req_valid), 64'd0);
        end
        bus_if.decode_ready = 1'b1;
        step();
        check_val("release_valid", 64'(bus_if.fetch_valid), 64'd0);
        check_val("release_req", 64'(bus_if.imem_req_valid), 64'd1);
        check_val("release_addr", 64'(bus_if.imem_addr), 64'h0008);

        // Redirect while waiting; late response must be dropped.
        rsp_lat = 2;
        bus_if.imem_req_ready = 1'b1;
        step();
        bus_if.imem_req_ready = 1'b0;
        bus_if.isbranchtaken  = 1'b1;
        bus_if.branchpc       = 16'h0040;
        step();
        bus_if.isbranchtaken  = 1'b0;
        check_val("drain_no_req", 64'(bus_if.imem_req_valid), 64'd0);
        step();
        check_val("drain_fetch_valid", 64'(bus_if.fetch_valid), 64'd0);
        check_val("wait_redir_req", 64'(bus_if.imem_req_valid), 64'd1);
        check_val("wait_redir_addr", 64'(bus_if.imem_addr), 64'h0040);
        rsp_lat = 1;
        push_exp(16'h0040, 2'b11);
        bus_if.imem_req_ready = 1'b1;
        run_until_consumed(1);

        // Unaligned redirect in HOLD with decode_ready high: bundle killed.
        bus_if.decode_ready   = 1'b0;
        bus_if.imem_req_ready = 1'b1;
        wait_fetch_valid();
        bus_if.imem_req_ready = 1'b0;
        check_val("hold42_pc", 64'(bus_if.fetch_pc), 64'h0042);
        bus_if.isbranchtaken  = 1'b1;
        bus_if.branchpc       = 16'h0013;
        bus_if.decode_ready   = 1'b1;
        step();
        bus_if.isbranchtaken  = 1'b0;
        check_val("kill_valid", 64'(bus_if.fetch_valid), 64'd0);
        check_val("kill_mask", 64'(bus_if.fetch_slot_valid), 64'd0);
        check_val("unaligned_addr", 64'(bus_if.imem_addr), 64'h0012);
        push_exp(16'h0012, 2'b10);
        push_exp(16'h0014, 2'b11);
        bus_if.imem_req_ready = 1'b1;
        run_until_consumed(2);

        // Redirect in the same cycle as the request handshake.
        bus_if.imem_req_ready = 1'b1;
        bus_if.isbranchtaken  = 1'b1;
        bus_if.branchpc       = 16'h0080;
        step();
        bus_if.imem_req_ready = 1'b0;
        bus_if.isbranchtaken  = 1'b0;
        check_val("req_redir_drain", 64'(bus_if.imem_req_valid), 64'd0);
        step();
        check_val("req_redir_req", 64'(bus_if.imem_req_valid), 64'd1);
        check_val("req_redir_addr", 64'(bus_if.imem_addr), 64'h0080);
        push_exp(16'h0080, 2'b11);
        bus_if.imem_req_ready = 1'b1;
        run_until_consumed(1);

        // PC wrap at the top of the address space.
        bus_if.isbranchtaken = 1'b1;
        bus_if.branchpc      = 16'hFFFE;
        step();
        bus_if.isbranchtaken = 1'b0;
        check_val("wrap_start_addr", 64'(bus_if.imem_addr), 64'hFFFE);
        push_exp(16'hFFFE, 2'b11);
        push_exp(16'h0000, 2'b11);
        bus_if.imem_req_ready = 1'b1;
        run_until_consumed(2);
        check_val("wrap_next_addr", 64'(bus_if.imem_addr), 64'h0002);

        // Asynchronous reset in the middle of WAIT.
        rsp_lat = 3;
        bus_if.imem_req_ready = 1'b1;
        step();
        bus_if.imem_req_ready = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        check_all_zero("async_rst");
        step();
        step();
        rst = 1'b0;
        rsp_lat = 1;
        step();
        check_val("post_rst_req", 64'(bus_if.imem_req_valid), 64'd1);
        check_val("post_rst_addr", 64'(bus_if.imem_addr), 64'h0000);
        push_exp(16'h0000, 2'b11);
        bus_if.imem_req_ready = 1'b1;
        run_until_consumed(1);

        check_val("sb_leftover", 64'(sb_q.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors_cnt, checks_cnt);
        $finish;
    end

endmodule
